// File: rtl/addrdecode_range.sv
// Pipelined range-based address decoder with response-ordering hold-off and an outstanding-transaction counter.
// Optional error-request counter (o_errcnt/i_errclr) is built when ADDRDECODE_RANGE_ERRCNT_EN is defined.
module addrdecode_range #(
    parameter int                NS             = 4,
    parameter int                AW             = 32,
    parameter int                DW             = 32,
    parameter logic [NS*AW-1:0]  SLAVE_BASE     = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0]  SLAVE_LAST     = {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF},
    parameter logic [NS-1:0]     ACCESS_ALLOWED = '1,
    parameter int                LGMAXPEND      = 4,
    parameter bit                OPT_LOWPOWER   = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    output logic                 o_stall,
    input  logic [AW-1:0]        i_addr,
    input  logic [DW-1:0]        i_data,
    output logic                 o_valid,
    input  logic                 i_stall,
    output logic [NS:0]          o_decode,
    output logic [AW-1:0]        o_addr,
    output logic [DW-1:0]        o_data,
    input  logic                 i_retire,
    output logic [LGMAXPEND-1:0] o_pending,
`ifdef ADDRDECODE_RANGE_ERRCNT_EN
    output logic [15:0]          o_errcnt,
    input  logic                 i_errclr,
`endif
    output logic                 o_empty
);
    localparam int IW = $clog2(NS + 1);
    localparam logic [LGMAXPEND-1:0] MAXPEND = '1;

    logic [NS-1:0]        match;
    logic [IW-1:0]        dec_idx;
    logic [NS:0]          dec_onehot;
    logic                 full, order_block, accept;

    logic                 valid_q, valid_d;
    logic [NS:0]          decode_q, decode_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;
    logic [IW-1:0]        last_dest_q, last_dest_d;
    logic [LGMAXPEND-1:0] pending_q, pending_d;

    // Unsigned inclusive range test; a range with LAST < BASE can never satisfy both bounds.
    for (genvar gi = 0; gi < NS; gi++) begin : g_match
        assign match[gi] = ACCESS_ALLOWED[gi]
                        && (i_addr >= SLAVE_BASE[gi*AW +: AW])
                        && (i_addr <= SLAVE_LAST[gi*AW +: AW]);
    end

    // Scan from the top down so the lowest matching index overwrites the others.
    always_comb begin
        dec_idx = IW'(NS);
        for (int k = NS - 1; k >= 0; k--) begin
            if (match[k]) dec_idx = IW'(k);
        end
    end

    for (genvar gi = 0; gi <= NS; gi++) begin : g_onehot
        assign dec_onehot[gi] = (dec_idx == IW'(gi));
    end

    assign full        = (pending_q == MAXPEND);
    assign order_block = i_valid && !o_empty && (dec_idx != last_dest_q);
    assign o_stall     = (valid_q && i_stall) || order_block || full;
    assign accept      = i_valid && !o_stall;

    always_comb begin
        valid_d     = valid_q;
        decode_d    = decode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_dest_d = last_dest_q;
        if (accept) begin
            valid_d     = 1'b1;
            decode_d    = dec_onehot;
            addr_d      = i_addr;
            data_d      = i_data;
            last_dest_d = dec_idx;
        end else if (!valid_q || !i_stall) begin
            valid_d = 1'b0;
            if (OPT_LOWPOWER) begin
                decode_d = '0;
                addr_d   = '0;
                data_d   = '0;
            end
        end
    end

    // Retire on an empty count is dropped; accept cannot occur while full.
    always_comb begin
        pending_d = pending_q;
        case ({accept, i_retire && !o_empty})
            2'b10:   pending_d = pending_q + LGMAXPEND'(1);
            2'b01:   pending_d = pending_q - LGMAXPEND'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q     <= 1'b0;
            decode_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_dest_q <= '0;
            pending_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            decode_q    <= decode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_dest_q <= last_dest_d;
            pending_q   <= pending_d;
        end
    end

`ifdef ADDRDECODE_RANGE_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (i_errclr)
            errcnt_d = '0;
        else if (accept && (dec_idx == IW'(NS)) && (errcnt_q != 16'hFFFF))
            errcnt_d = errcnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) errcnt_q <= '0;
        else            errcnt_q <= errcnt_d;
    end

    assign o_errcnt = errcnt_q;
`endif

    assign o_valid   = valid_q;
    assign o_decode  = decode_q;
    assign o_addr    = addr_q;
    assign o_data    = data_q;
    assign o_pending = pending_q;
    assign o_empty   = (pending_q == '0);

endmodule

// File: tb/tb_addrdecode_range.sv
// Directed bench for addrdecode_range: vector table for the decode map plus sequences for ordering, full, hold and reset.
`timescale 1ns/1ps
module tb_addrdecode_range;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, i_valid, i_stall, i_retire;
    logic [31:0] i_addr, i_data;
    logic        o_stall, o_valid, o_empty;
    logic [4:0]  o_decode;
    logic [31:0] o_addr, o_data;
    logic [3:0]  o_pending;

    logic        ov_valid, ov_stall, ov_retire, ov_ostall, ov_ovalid, ov_empty;
    logic [31:0] ov_addr, ov_data, ov_oaddr, ov_odata;
    logic [2:0]  ov_decode;
    logic [3:0]  ov_pending;

`ifdef ADDRDECODE_RANGE_ERRCNT_EN
    logic [15:0] o_errcnt, ov_errcnt;
    logic        i_errclr;
`endif

    addrdecode_range dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_stall(o_stall),
        .i_addr(i_addr), .i_data(i_data), .o_valid(o_valid), .i_stall(i_stall),
        .o_decode(o_decode), .o_addr(o_addr), .o_data(o_data), .i_retire(i_retire),
        .o_pending(o_pending),
`ifdef ADDRDECODE_RANGE_ERRCNT_EN
        .o_errcnt(o_errcnt), .i_errclr(i_errclr),
`endif
        .o_empty(o_empty)
    );

    // Overlapping ranges: slave0 [0,0xFFFF], slave1 [0x8000,0x1FFFF].
    addrdecode_range #(
        .NS(2),
        .SLAVE_BASE({32'h0000_8000, 32'h0000_0000}),
        .SLAVE_LAST({32'h0001_FFFF, 32'h0000_FFFF})
    ) dut_ov (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(ov_valid), .o_stall(ov_ostall),
        .i_addr(ov_addr), .i_data(ov_data), .o_valid(ov_ovalid), .i_stall(ov_stall),
        .o_decode(ov_decode), .o_addr(ov_oaddr), .o_data(ov_odata), .i_retire(ov_retire),
        .o_pending(ov_pending),
`ifdef ADDRDECODE_RANGE_ERRCNT_EN
        .o_errcnt(ov_errcnt), .i_errclr(i_errclr),
`endif
        .o_empty(ov_empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  dec;
    } vec_t;
    vec_t vecs[10];

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  dec;
    } ovec_t;
    ovec_t ovecs[4];

    logic        accepted;

    initial begin
        vecs[0] = '{32'h1000_0004, 5'b00010};
        vecs[1] = '{32'h0000_0000, 5'b00001};
        vecs[2] = '{32'h0FFF_FFFF, 5'b00001};
        vecs[3] = '{32'h1000_0000, 5'b00010};
        vecs[4] = '{32'h1FFF_FFFF, 5'b00010};
        vecs[5] = '{32'h2FFF_FFFF, 5'b00100};
        vecs[6] = '{32'h3000_0000, 5'b01000};
        vecs[7] = '{32'h3FFF_FFFF, 5'b01000};
        vecs[8] = '{32'h4000_0000, 5'b10000};
        vecs[9] = '{32'hFFFF_FFFF, 5'b10000};
        ovecs[0] = '{32'h0000_9000, 3'b001};
        ovecs[1] = '{32'h0000_8000, 3'b001};
        ovecs[2] = '{32'h0001_0000, 3'b010};
        ovecs[3] = '{32'h0002_0000, 3'b100};

        rst_n = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_retire = 1'b0;
        i_addr = '0; i_data = '0;
        ov_valid = 1'b0; ov_stall = 1'b0; ov_retire = 1'b0; ov_addr = '0; ov_data = '0;
`ifdef ADDRDECODE_RANGE_ERRCNT_EN
        i_errclr = 1'b0;
`endif
        #2;
        check("reset o_valid",   {63'd0, o_valid}, 64'd0);
        check("reset o_decode",  {59'd0, o_decode}, 64'd0);
        check("reset o_pending", {60'd0, o_pending}, 64'd0);
        check("reset o_empty",   {63'd0, o_empty}, 64'd1);
        check("reset o_addr",    {32'd0, o_addr}, 64'd0);
        check("reset o_data",    {32'd0, o_data}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Decode map: each vector accepted, then retired so the next slave is not ordering-blocked.
        for (int v = 0; v < 10; v++) begin
            i_valid = 1'b1; i_addr = vecs[v].addr; i_data = vecs[v].addr ^ 32'hA5A5_A5A5;
            #1;
            check($sformatf("vec%0d o_stall", v), {63'd0, o_stall}, 64'd0);
            tick();
            i_valid = 1'b0;
            check($sformatf("vec%0d o_valid", v),   {63'd0, o_valid}, 64'd1);
            check($sformatf("vec%0d o_decode", v),  {59'd0, o_decode}, {59'd0, vecs[v].dec});
            check($sformatf("vec%0d o_addr", v),    {32'd0, o_addr}, {32'd0, vecs[v].addr});
            check($sformatf("vec%0d o_data", v),    {32'd0, o_data}, {32'd0, vecs[v].addr ^ 32'hA5A5_A5A5});
            check($sformatf("vec%0d o_pending", v), {60'd0, o_pending}, 64'd1);
            i_retire = 1'b1;
            tick();
            i_retire = 1'b0;
            check($sformatf("vec%0d retired", v), {60'd0, o_pending}, 64'd0);
        end

        // Retire with nothing outstanding must not wrap the count.
        i_retire = 1'b1; tick(); i_retire = 1'b0;
        check("retire on empty", {60'd0, o_pending}, 64'd0);

        // Ordering: a different-slave request waits until the earlier one retires.
        i_valid = 1'b1; i_addr = 32'h2000_0000; i_data = 32'h1111_1111;
        tick();
        check("ord first decode", {59'd0, o_decode}, 64'b00100);
        i_addr = 32'h0000_0010; i_data = 32'h2222_2222;
        #1;
        check("ord second stall", {63'd0, o_stall}, 64'd1);
        tick(); tick();
        check("ord still stalled", {63'd0, o_stall}, 64'd1);
        check("ord pending held",  {60'd0, o_pending}, 64'd1);
        check("ord o_valid drained", {63'd0, o_valid}, 64'd0);
        i_retire = 1'b1;
        tick();
        i_retire = 1'b0;
        check("ord stall released", {63'd0, o_stall}, 64'd0);
        tick();
        i_valid = 1'b0;
        check("ord second decode", {59'd0, o_decode}, 64'b00001);
        check("ord second addr",   {32'd0, o_addr}, 64'h10);
        check("ord second pending", {60'd0, o_pending}, 64'd1);
        i_retire = 1'b1; tick(); i_retire = 1'b0;

        // Fill to the outstanding limit with same-slave streaming.
        i_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            i_addr = 32'h1000_0000 + 32'(i * 4); i_data = 32'(i);
            tick();
        end
        check("full pending", {60'd0, o_pending}, 64'd15);
        check("full stall",   {63'd0, o_stall}, 64'd1);
        i_addr = 32'h1000_0100; i_data = 32'hDEAD_BEEF;
        i_retire = 1'b1;
        tick();
        i_retire = 1'b0;
        accepted = 1'b0;
        for (int c = 0; c < 4 && !accepted; c++) begin
            if (!o_stall) accepted = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        check("full accepted after retire", {63'd0, accepted}, 64'd1);
        check("full refill addr",    {32'd0, o_addr}, 64'h1000_0100);
        check("full refill pending", {60'd0, o_pending}, 64'd15);

        // Downstream hold: outputs frozen while stalled.
        i_stall = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            check($sformatf("hold%0d o_valid", h),  {63'd0, o_valid}, 64'd1);
            check($sformatf("hold%0d o_addr", h),   {32'd0, o_addr}, 64'h1000_0100);
            check($sformatf("hold%0d o_data", h),   {32'd0, o_data}, 64'hDEAD_BEEF);
            check($sformatf("hold%0d o_decode", h), {59'd0, o_decode}, 64'b00010);
            check($sformatf("hold%0d o_stall", h),  {63'd0, o_stall}, 64'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst o_valid",   {63'd0, o_valid}, 64'd0);
        check("async rst o_pending", {60'd0, o_pending}, 64'd0);
        check("async rst o_empty",   {63'd0, o_empty}, 64'd1);
        i_stall = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Overlapping ranges resolve to the lowest index.
        for (int v = 0; v < 4; v++) begin
            ov_valid = 1'b1; ov_addr = ovecs[v].addr; ov_data = 32'(v);
            tick();
            ov_valid = 1'b0;
            check($sformatf("ovl%0d o_decode", v), {61'd0, ov_decode}, {61'd0, ovecs[v].dec});
            ov_retire = 1'b1; tick(); ov_retire = 1'b0;
        end

`ifdef ADDRDECODE_RANGE_ERRCNT_EN
        i_errclr = 1'b1; tick(); i_errclr = 1'b0;
        check("errcnt cleared", {48'd0, o_errcnt}, 64'd0);
        i_valid = 1'b1; i_addr = 32'hF000_0000;
        for (int e = 0; e < 3; e++) begin
            tick();
            check($sformatf("err%0d o_decode", e), {59'd0, o_decode}, 64'b10000);
        end
        i_valid = 1'b0;
        check("errcnt three", {48'd0, o_errcnt}, 64'd3);
        i_errclr = 1'b1; tick(); i_errclr = 1'b0;
        check("errcnt after clr", {48'd0, o_errcnt}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/addrdecode_range.md
Name: addrdecode_range

Overview:
- Pipelined address decoder for bus crossbars. Routes each request to one of NS slaves using arbitrary inclusive [base, last] address ranges; no power-of-two alignment is required.
- Registers the decode and the payload, with valid/stall handshaking (READY = !STALL).
- Enforces response ordering: tracks outstanding transactions and holds off any request to a different slave until all earlier ones have retired.
- Sits between a master port and the crossbar arbiter.

Parameters:
- NS, 4, number of slaves.
- AW, 32, address width.
- DW, 32, payload width.
- SLAVE_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, NS*AW packed inclusive base addresses; slave k at [k*AW +: AW].
- SLAVE_LAST, {32'h3FFF_FFFF, 32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0FFF_FFFF}, NS*AW packed inclusive last addresses.
- ACCESS_ALLOWED, all ones, NS-bit mask; a cleared bit means that slave never matches.
- LGMAXPEND, 4, log2 of the outstanding limit; at most 2^LGMAXPEND-1 transactions outstanding.
- OPT_LOWPOWER, 0, when 1, o_addr, o_data and o_decode are forced to 0 whenever !o_valid.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- o_stall  out  1  request not accepted this cycle
- i_addr  in  AW  request address
- i_data  in  DW  request payload
- o_valid  out  1  decoded request valid
- i_stall  in  1  downstream stall
- o_decode  out  NS+1  one-hot target; bit NS = no slave matched (error slave)
- o_addr  out  AW  registered address
- o_data  out  DW  registered payload
- i_retire  in  1  one outstanding transaction completed (response returned)
- o_pending  out  LGMAXPEND  outstanding transaction count
- o_empty  out  1  o_pending == 0

Behaviour:
- Reset (async assert, sync deassert):
  - o_valid=0, o_decode=0, o_pending=0, o_empty=1, last-destination register=0.
  - o_addr and o_data reset to 0.
- Match rule: slave k matches when ACCESS_ALLOWED[k] && SLAVE_BASE[k] <= i_addr <= SLAVE_LAST[k], using unsigned AW-bit compares.
  - If several slaves overlap, the lowest index wins, so the decode is always one-hot.
  - If no slave matches, the request is routed to bit NS.
  - A slave with LAST < BASE never matches.
- Pipeline: single register stage, latency 1. Input is accepted (i_valid && !o_stall) at edge N; o_valid, o_decode, o_addr and o_data are presented after edge N.
- While o_valid && i_stall, all outputs hold stable.
- Stall: o_stall = (o_valid && i_stall) || order_block || full.
  - full: o_pending == 2^LGMAXPEND-1.
  - order_block: i_valid && !o_empty && decode(i_addr) != last_dest.
  - last_dest includes the error index NS, so error requests are also ordered.
- last_dest is loaded with the decoded index on every accepted request.
- o_pending counting:
  - Increments on each accepted request.
  - Decrements on i_retire.
  - Simultaneous accept and retire leaves it unchanged.
  - i_retire while o_pending == 0 is ignored; the count never wraps.
- Counting starts at acceptance, so a request still held in the output register already counts as pending.
- Same-destination requests stream at one per clock while not full.
- OPT_LOWPOWER=1: when no new request is loaded and !i_stall (or !o_valid), o_addr, o_data and o_decode clear to 0.
- Combinational paths: o_stall depends on i_stall, i_valid and i_addr. There is no path from i_stall to o_valid.
- Reset asserted mid-transaction: the in-flight output and all pending counts are discarded immediately.

Optional Feature:
- Macro ADDRDECODE_RANGE_ERRCNT_EN.
- Defined:
  - Adds output port o_errcnt (16 bits), reset 0.
  - Increments, saturating at 16'hFFFF, on each accepted request that decodes to bit NS.
  - Adds input i_errclr, which zeroes the count synchronously; i_errclr has priority over a simultaneous increment.
- Not defined: neither port exists and there is no counter logic.

Test Plan:
- Reset, then i_valid=1 with i_addr=32'h1000_0004 and i_stall=0 -> next cycle o_valid=1, o_decode=5'b00010, o_addr=32'h1000_0004, o_pending=1.
- Two back-to-back requests to 32'h2000_0000 and 32'h0000_0010 with no retire -> first accepted (o_decode=5'b00100); second sees o_stall=1 until i_retire is pulsed, then is accepted with o_decode=5'b00001.
- Overlap config: slave0 [0,0xFFFF], slave1 [0x8000,0x1FFFF]; i_addr=0x9000 -> o_decode=bit0.
- Fifteen same-slave requests with LGMAXPEND=4 and no retire -> o_pending=15 and o_stall=1. Then pulse i_retire together with a new request -> request accepted, o_pending stays 15.
- Hold i_stall=1 with o_valid=1 for 3 cycles -> o_addr, o_data and o_decode stay stable and o_stall=1. Drop i_reset_n mid-hold -> o_valid=0 and o_pending=0 asynchronously.
- With ADDRDECODE_RANGE_ERRCNT_EN: three accepted requests to 32'hF000_0000 -> o_decode=5'b10000 each and o_errcnt=3. Then i_errclr -> o_errcnt=0.
